psk_frame_scheduler: RTL and testbench

PSK_FRAME_SCHEDULER -- requirements
Module: psk_frame_scheduler

---
 rtl/psk_frame_scheduler_if.sv | 31 +++
 rtl/psk_frame_scheduler.sv | 179 +++++++++++++++++
 tb/tb_psk_frame_scheduler.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/psk_frame_scheduler_if.sv
// -----------------------------------------------------------------------------
// psk_frame_scheduler_if
// Bundles the handshake signals of the PSK frame scheduler: the control pair
// (enable/start), the upstream first-word-fall-through FIFO port, the
// modulator port and the status outputs.
//   master : drives control, FIFO head/empty and the modulator consume strobe
//   slave  : the scheduler itself (pops the FIFO, presents bytes, reports status)
// -----------------------------------------------------------------------------
interface psk_frame_scheduler_if;
  logic        enable;
  logic        start;
  logic [7:0]  src_data;
  logic        src_empty;
  logic        src_read;
  logic [7:0]  mod_sample;
  logic        mod_empty;
  logic        mod_read;
  logic        busy;
  logic        frame_done;
  logic [15:0] underrun_count;

  modport master (
    output enable, start, src_data, src_empty, mod_read,
    input  src_read, mod_sample, mod_empty, busy, frame_done, underrun_count
  );

  modport slave (
    input  enable, start, src_data, src_empty, mod_read,
    output src_read, mod_sample, mod_empty, busy, frame_done, underrun_count
  );
endinterface

// File: rtl/psk_frame_scheduler.sv
// -----------------------------------------------------------------------------
// psk_frame_scheduler
// Builds one frame per start request: PREAMBLE_LEN copies of PREAMBLE_BYTE
// followed by FRAME_LEN payload bytes pulled from an upstream FWFT FIFO.
// The modulator is fed continuously; a payload slot with no byte ready is
// filled with IDLE_BYTE (underrun) and the frame is stretched by one slot.
// A one-byte holding register prefetches payload during the preamble and
// refills in the same cycle it is consumed, so steady reads see no bubble.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : psk_frame_scheduler_if.slave
//          enable/start, src_data/src_empty/src_read,
//          mod_sample/mod_empty/mod_read, busy/frame_done/underrun_count
//
// Build option:
//   PSK_SCHED_UNDERRUN_COUNT_EN - when defined, underrun_count counts
//   IDLE_BYTE payload slots (saturating, cleared at frame start); otherwise
//   underrun_count is tied to zero.
// -----------------------------------------------------------------------------
module psk_frame_scheduler #(
  parameter int unsigned PREAMBLE_LEN  = 16,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
  parameter int unsigned FRAME_LEN     = 64,
  parameter logic [7:0]  IDLE_BYTE     = 8'h00
) (
  input logic                  clk,
  input logic                  rst,
  psk_frame_scheduler_if.slave bus
);

  localparam int unsigned PRE_W = $clog2(PREAMBLE_LEN + 1);
  localparam int unsigned FRM_W = $clog2(FRAME_LEN + 1);

  localparam logic [PRE_W-1:0] PRE_ZERO_C = {PRE_W{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE_C  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST_C = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [FRM_W-1:0] FRM_ZERO_C = {FRM_W{1'b0}};
  localparam logic [FRM_W-1:0] FRM_ONE_C  = FRM_W'(1);
  localparam logic [FRM_W-1:0] FRM_LEN_C  = FRM_W'(FRAME_LEN);
  localparam logic [FRM_W-1:0] FRM_LAST_C = FRM_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t           state_r;
  logic [PRE_W-1:0] pre_cnt_r;
  logic [FRM_W-1:0] fetch_cnt_r;
  logic [FRM_W-1:0] sent_cnt_r;
  logic [7:0]       hold_r;
  logic             hold_valid_r;
  logic             frame_done_r;

  logic             run_s;
  logic             in_pre_s;
  logic             in_pay_s;
  logic             start_s;
  logic             take_pre_s;
  logic             take_pay_s;
  logic             fetch_room_s;
  logic             src_read_s;
  logic [7:0]       mod_sample_s;

  // run_s includes rst so the FIFO/modulator strobes are quiet during reset
  assign run_s        = bus.enable & rst;
  assign in_pre_s     = (state_r == PRE);
  assign in_pay_s     = (state_r == PAY);
  assign start_s      = run_s & (state_r == IDLE) & bus.start;
  assign take_pre_s   = run_s & in_pre_s & bus.mod_read;
  // a payload read only counts when a real byte is held; otherwise it is an underrun
  assign take_pay_s   = run_s & in_pay_s & bus.mod_read & hold_valid_r;
  assign fetch_room_s = (fetch_cnt_r < FRM_LEN_C);
  // refill when the holding register is empty or is being emptied this cycle
  assign src_read_s   = run_s & (in_pre_s | in_pay_s) & ~bus.src_empty &
                        fetch_room_s & (~hold_valid_r | take_pay_s);

  // Byte presented to the modulator, decoded from registered state
  always_comb begin
    mod_sample_s = IDLE_BYTE;
    case (state_r)
      IDLE: mod_sample_s = IDLE_BYTE;
      PRE:  mod_sample_s = PREAMBLE_BYTE;
      PAY: begin
        if (hold_valid_r) begin
          mod_sample_s = hold_r;
        end else begin
          mod_sample_s = IDLE_BYTE;
        end
      end
      default: mod_sample_s = IDLE_BYTE;
    endcase
  end

  // Frame sequencer: state, counters, holding register and frame_done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      pre_cnt_r    <= PRE_ZERO_C;
      fetch_cnt_r  <= FRM_ZERO_C;
      sent_cnt_r   <= FRM_ZERO_C;
      hold_r       <= 8'h00;
      hold_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
    end else if (bus.enable) begin
      frame_done_r <= 1'b0;

      // holding register: a refill wins over the consume-clear
      if (src_read_s) begin
        hold_r       <= bus.src_data;
        hold_valid_r <= 1'b1;
        fetch_cnt_r  <= fetch_cnt_r + FRM_ONE_C;
      end else if (take_pay_s) begin
        hold_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r     <= PRE;
            pre_cnt_r   <= PRE_ZERO_C;
            fetch_cnt_r <= FRM_ZERO_C;
            sent_cnt_r  <= FRM_ZERO_C;
          end
        end
        PRE: begin
          if (take_pre_s) begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE_C;
            if (pre_cnt_r == PRE_LAST_C) begin
              state_r <= PAY;
            end
          end
        end
        PAY: begin
          if (take_pay_s) begin
            sent_cnt_r <= sent_cnt_r + FRM_ONE_C;
            if (sent_cnt_r == FRM_LAST_C) begin
              state_r      <= IDLE;
              frame_done_r <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef PSK_SCHED_UNDERRUN_COUNT_EN
  logic        underrun_s;
  logic [15:0] underrun_cnt_r;

  assign underrun_s = run_s & in_pay_s & bus.mod_read & ~hold_valid_r;

  // Saturating count of IDLE_BYTE payload slots, restarted with each frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun_cnt_r <= 16'h0000;
    end else if (start_s) begin
      underrun_cnt_r <= 16'h0000;
    end else if (underrun_s && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'h0001;
    end
  end

  assign bus.underrun_count = underrun_cnt_r;
`else
  assign bus.underrun_count = 16'h0000;
`endif

  assign bus.src_read   = src_read_s;
  assign bus.mod_sample = mod_sample_s;
  assign bus.mod_empty  = ~run_s;
  assign bus.busy       = (state_r != IDLE);
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_psk_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_psk_frame_scheduler
// Directed scenarios (nominal, underrun, back-to-back, freeze, reset mid-frame)
// followed by randomized frames. The bench owns an upstream FIFO queue and
// records every byte the modulator takes; each frame is compared with the
// expected stream: PREAMBLE_LEN preamble bytes then the payload in order.
// -----------------------------------------------------------------------------
module tb_psk_frame_scheduler;
  localparam int PL = 4;
  localparam int FL = 3;

`ifdef PSK_SCHED_UNDERRUN_COUNT_EN
  localparam logic [15:0] UR_ONE = 16'd1;
`else
  localparam logic [15:0] UR_ONE = 16'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psk_frame_scheduler_if bus();

  psk_frame_scheduler #(
    .PREAMBLE_LEN (PL),
    .PREAMBLE_BYTE(8'hAA),
    .FRAME_LEN    (FL),
    .IDLE_BYTE    (8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  logic       last_done;
  logic       last_src_read;
  logic [7:0] last_sample;
  logic [7:0] pop_v;
  logic [7:0] fifo_q[$];
  logic [7:0] taken_q[$];
  logic [7:0] pay_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample combinational outputs, advance the edge
  task automatic cyc(input logic rd, input logic st);
    bus.mod_read  = rd;
    bus.start     = st;
    bus.src_empty = (fifo_q.size() == 0) ? 1'b1 : 1'b0;
    bus.src_data  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    #1;
    last_src_read = bus.src_read;
    last_sample   = bus.mod_sample;
    if (rd && bus.enable) taken_q.push_back(bus.mod_sample);
    @(posedge clk);
    #1;
    if (last_src_read) pop_v = fifo_q.pop_front();
    bus.mod_read = 1'b0;
    bus.start    = 1'b0;
    last_done    = bus.frame_done;
    if (bus.frame_done) done_cnt++;
  endtask

  task automatic do_reads(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
    end
  endtask

  task automatic begin_frame(input string tag);
    taken_q.delete();
    done_cnt = 0;
    cyc(1'b0, 1'b1);
    chk({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
  endtask

  // Expected stream: preamble, then the given payload slots in order
  task automatic check_stream(input string tag, input logic [7:0] pay[$]);
    logic [7:0] exp_q[$];
    for (int i = 0; i < PL; i++) exp_q.push_back(8'hAA);
    foreach (pay[i]) exp_q.push_back(pay[i]);
    chk({tag, "_len"}, 32'(taken_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < taken_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(taken_q[i]), 32'(exp_q[i]));
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    rst           = 1'b0;
    bus.enable    = 1'b1;
    bus.start     = 1'b0;
    bus.mod_read  = 1'b0;
    bus.src_data  = 8'h00;
    bus.src_empty = 1'b1;
    #1;
    chk("rst_busy",     32'(bus.busy),           32'd0);
    chk("rst_src_read", 32'(bus.src_read),       32'd0);
    chk("rst_sample",   32'(bus.mod_sample),     32'h00);
    chk("rst_mod_empty",32'(bus.mod_empty),      32'd1);
    chk("rst_done",     32'(bus.frame_done),     32'd0);
    chk("rst_underrun", 32'(bus.underrun_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    chk("idle_mod_empty", 32'(bus.mod_empty), 32'd0);
    chk("idle_busy",      32'(bus.busy),      32'd0);

    // Scenario 1: nominal frame, reads every 8 cycles
    fifo_q = '{8'h11, 8'h22, 8'h33};
    begin_frame("s1");
    do_reads(PL + FL, 7);
    chk("s1_done_pulse", 32'(last_done), 32'd1);
    chk("s1_busy_fall",  32'(bus.busy),  32'd0);
    cyc(1'b0, 1'b0);
    chk("s1_done_single", 32'(last_done), 32'd0);
    chk("s1_underrun", 32'(bus.underrun_count), 32'd0);
    pay_q = '{8'h11, 8'h22, 8'h33};
    check_stream("s1", pay_q);

    // Scenario 2: FIFO empty until after the 5th read
    fifo_q.delete();
    begin_frame("s2");
    do_reads(PL + 1, 7);
    chk("s2_underrun", 32'(bus.underrun_count), 32'(UR_ONE));
    chk("s2_still_busy", 32'(bus.busy), 32'd1);
    fifo_q = '{8'h11, 8'h22, 8'h33};
    do_reads(FL, 7);
    chk("s2_done_pulse", 32'(last_done), 32'd1);
    chk("s2_underrun_end", 32'(bus.underrun_count), 32'(UR_ONE));
    pay_q = '{8'h00, 8'h11, 8'h22, 8'h33};
    check_stream("s2", pay_q);

    // Scenario 3: payload read every cycle, refilled in the same cycle
    fifo_q = '{8'h11, 8'h22, 8'h33};
    begin_frame("s3");
    chk("s3_underrun_cleared", 32'(bus.underrun_count), 32'd0);
    do_reads(PL, 2);
    cyc(1'b1, 1'b0);
    chk("s3_pop1",   32'(last_src_read), 32'd1);
    chk("s3_sample1",32'(last_sample),   32'h11);
    cyc(1'b1, 1'b0);
    chk("s3_pop2",   32'(last_src_read), 32'd1);
    chk("s3_sample2",32'(last_sample),   32'h22);
    cyc(1'b1, 1'b0);
    chk("s3_pop3",   32'(last_src_read), 32'd0);
    chk("s3_sample3",32'(last_sample),   32'h33);
    chk("s3_done_pulse", 32'(last_done), 32'd1);
    pay_q = '{8'h11, 8'h22, 8'h33};
    check_stream("s3", pay_q);

    // Scenario 4: freeze mid-payload, start pulses while busy
    fifo_q = '{8'h44, 8'h55, 8'h66};
    begin_frame("s4");
    do_reads(PL + 1, 1);
    bus.enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc((i % 4) == 0, i == 10);
      chk("s4_frz_src_read", 32'(last_src_read), 32'd0);
      chk("s4_frz_empty",    32'(bus.mod_empty), 32'd1);
      chk("s4_frz_sample",   32'(last_sample),   32'h55);
    end
    chk("s4_frz_fifo", 32'(fifo_q.size()), 32'd1);
    bus.enable = 1'b1;
    cyc(1'b0, 1'b1);
    chk("s4_start_ignored", 32'(bus.mod_sample), 32'h55);
    do_reads(FL - 1, 1);
    chk("s4_done_pulse", 32'(last_done), 32'd1);
    pay_q = '{8'h44, 8'h55, 8'h66};
    check_stream("s4", pay_q);

    // Scenario 5: reset in the middle of the payload
    fifo_q = '{8'h77, 8'h88, 8'h99};
    begin_frame("s5");
    do_reads(PL + 1, 1);
    rst = 1'b0;
    #1;
    chk("s5_busy_async",  32'(bus.busy),       32'd0);
    chk("s5_sample_async",32'(bus.mod_sample), 32'h00);
    chk("s5_empty_async", 32'(bus.mod_empty),  32'd1);
    chk("s5_read_async",  32'(bus.src_read),   32'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("s5_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    fifo_q = '{8'hAB, 8'hCD, 8'hEF};
    begin_frame("s5b");
    do_reads(PL + FL, 3);
    pay_q = '{8'hAB, 8'hCD, 8'hEF};
    check_stream("s5b", pay_q);

    // Randomized frames: random gaps, freezes and ignored start pulses
    for (int f = 0; f < 8; f++) begin
      pay_q.delete();
      for (int i = 0; i < FL; i++) pay_q.push_back(8'($urandom));
      fifo_q = pay_q;
      begin_frame($sformatf("rnd%0d", f));
      for (int r = 0; r < PL + FL; r++) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.enable = 1'b0;
          repeat ($urandom_range(1, 4)) cyc(1'($urandom_range(0, 1)), 1'b0);
          bus.enable = 1'b1;
        end
        repeat ($urandom_range(0, 5)) cyc(1'b0, 1'($urandom_range(0, 1)));
        cyc(1'b1, 1'b0);
      end
      chk($sformatf("rnd%0d_busy_end", f), 32'(bus.busy), 32'd0);
      chk($sformatf("rnd%0d_underrun", f), 32'(bus.underrun_count), 32'd0);
      check_stream($sformatf("rnd%0d", f), pay_q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
